commit_trace_buffer: RTL and testbench
======================================

# commit_trace_buffer

Parametrised, synthesizable commit monitor for the pipelined RV32I core. It accepts up to CHANNELS commit events per cycle (register writeback, load, store, branch/jump), tags each with a sequence number, and buffers them in a multi-push FIFO that a bench or debug port drains. It also detects halt (branch-to-self repeated HALT_REPEAT times) and commit starvation (timeout), and counts events dropped on overflow.

## Interface
- CHANNELS, 2: commit sources per cycle; channel 0 is oldest in program order.
- DEPTH, 16: FIFO entries; power of 2, at least CHANNELS.
- HALT_REPEAT, 1: consecutive self-branch commits required to assert halt; at least 1.
- TIMEOUT_CYCLES, 100000: commit-free cycles before timeout asserts; at least 1.
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- commit_valid  in  CHANNELS  per-channel commit strobe.
- commit_kind  in  2*CHANNELS  per channel: 0 = reg, 1 = load, 2 = store, 3 = branch/jump.
- commit_pc  in  32*CHANNELS  PC of the committing instruction.
- commit_rd  in  5*CHANNELS  destination register.
- commit_data  in  32*CHANNELS  rd write data, load rdata or store wdata.
- commit_addr  in  32*CHANNELS  memory address (load/store) or branch target.
- commit_mbe  in  4*CHANNELS  byte mask (load/store); otherwise ignored.
- trace_ready  in  1  pop strobe from the consumer.
- trace_valid  out  1  head entry present.
- trace_kind, trace_rd, trace_mbe  out  2/5/4  head entry fields.
- trace_pc, trace_data, trace_addr, trace_order, trace_time  out  32 each  head entry fields.
- count  out  $clog2(DEPTH)+1  occupancy.
- overflow  out  1  sticky: at least one event dropped for lack of space.
- drop_count  out  16  saturating count of dropped events.
- halt  out  1  sticky halt detected.
- timeout  out  1  sticky timeout detected.

## Operation
- **Filtering.** A reg commit with rd = 0 is discarded. It is not recorded, not counted as a drop, and does not affect halt. It still resets the timeout counter.
- **Per-cycle processing.** Valid, unfiltered channels are processed in ascending index order.
- **Space accounting.** Free slots = DEPTH − count, using count from the start of the cycle. A same-cycle pop does not free space for a same-cycle push.
- **Acceptance.** The first `free` eligible events are written at wr_ptr, wr_ptr+1, … (mod DEPTH). Each accepted event gets trace_order = order_ctr + k, and order_ctr advances by the number accepted.
- **Overflow.** Eligible events beyond `free` are dropped: overflow is set and drop_count is incremented by the number dropped, saturating at 16'hFFFF. Dropped events still feed halt detection.
- **Halt detection.**
  - A branch event with commit_addr == commit_pc increments rep_ctr. Any other eligible event clears rep_ctr.
  - When rep_ctr reaches HALT_REPEAT, halt sets.
  - Events on higher-index channels in that same cycle are ignored: not recorded, not dropped, not counted.
  - Once halt = 1, all commits are ignored until reset. The FIFO still drains normally.
- **Timeout.** idle_ctr clears on any valid commit, including rd = 0 commits, and otherwise increments. timeout sets when idle_ctr reaches TIMEOUT_CYCLES; idle_ctr then holds. timeout does not block recording.
- **Pop.** trace_ready && trace_valid advances rd_ptr. trace_ready with an empty FIFO has no effect.
- **Reset.** All pointers, counters and sticky flags are cleared. Outputs: trace_valid 0, count 0, overflow 0, drop_count 0, halt 0, timeout 0, and all trace_* fields 0.
- **Field masking.** trace_* fields are forced to 0 whenever trace_valid = 0.

## Timing
- Push to visibility: an event accepted in cycle N is visible at the head (if the FIFO was empty) with trace_valid = 1 in cycle N+1. FIFO reads are registered or fall-through from registered storage; no combinational path from commit_* to trace_*.
- Pop: the head advances at the clock edge where trace_ready && trace_valid. The next entry is visible in the same cycle the pointer moves.
- count updates one cycle after push/pop: count(N+1) = count(N) + accepted − popped.
- halt, overflow and timeout assert in the cycle after the triggering event and stay high until reset.
- Wrap-around: pointers are $clog2(DEPTH)+1 bits. Full is count == DEPTH; empty is count == 0.
- Asynchronous reset mid-burst discards all buffered entries immediately.

## Configuration
- TRACE_TIMESTAMP_EN defined: a free-running 32-bit cycle counter (0 after reset, wraps at 2^32) is stored with each accepted entry and presented on trace_time.
- TRACE_TIMESTAMP_EN undefined: no counter or storage is built, and trace_time is tied to 0.

## Test plan
- **Single channel, three reg commits.** CHANNELS = 2, ch0 only, rd = 1/2/3 in consecutive cycles, trace_ready = 0 -> count = 3; trace_order = 0, 1, 2; drained in order.
- **rd = 0 filtering.** ch0 reg rd = 0 and ch1 load (addr 0x100, mbe 4'b1111) in the same cycle -> only the load is recorded, with order 0; count = 1; drop_count = 0.
- **Overflow.** DEPTH = 4, preloaded with 3 entries; both channels commit with trace_ready = 1 -> ch0 accepted, ch1 dropped; count stays 3 (one accepted, one popped); overflow = 1; drop_count = 1.
- **Halt with repeat.** HALT_REPEAT = 2; branch at pc 0x60 with target 0x60 on two consecutive cycles, then reg rd = 5 -> halt = 1 the cycle after the second branch; the rd = 5 commit is not recorded.
- **Halt mid-cycle.** HALT_REPEAT = 1; ch0 self-branch and ch1 store in the same cycle -> branch recorded, store ignored; drop_count unchanged.
- **Timeout.** TIMEOUT_CYCLES = 10 with no commits -> timeout rises on the 11th cycle after reset; a later commit is still recorded.
- **Timestamp (TRACE_TIMESTAMP_EN).** A commit in cycle 7 after reset -> trace_time = 7. With the macro undefined -> trace_time = 0.

Source files
------------

// File: rtl/commit_trace_buffer.sv
// Commit monitor: tags up to CHANNELS commits per cycle and queues them in a multi-push FIFO.
// Optional macro TRACE_TIMESTAMP_EN stores a free-running cycle count with every entry.
module commit_trace_buffer #(
   parameter int CHANNELS       = 2,
   parameter int DEPTH          = 16,
   parameter int HALT_REPEAT    = 1,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CHANNELS-1:0]       commit_valid,
   input  logic [2*CHANNELS-1:0]     commit_kind,
   input  logic [32*CHANNELS-1:0]    commit_pc,
   input  logic [5*CHANNELS-1:0]     commit_rd,
   input  logic [32*CHANNELS-1:0]    commit_data,
   input  logic [32*CHANNELS-1:0]    commit_addr,
   input  logic [4*CHANNELS-1:0]     commit_mbe,
   input  logic                      trace_ready,
   output logic                      trace_valid,
   output logic [1:0]                trace_kind,
   output logic [4:0]                trace_rd,
   output logic [3:0]                trace_mbe,
   output logic [31:0]               trace_pc,
   output logic [31:0]               trace_data,
   output logic [31:0]               trace_addr,
   output logic [31:0]               trace_order,
   output logic [31:0]               trace_time,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      overflow,
   output logic [15:0]               drop_count,
   output logic                      halt,
   output logic                      timeout
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   typedef enum logic [1:0] {KIND_REG, KIND_LOAD, KIND_STORE, KIND_BRANCH} kind_t;

   typedef struct packed {
      logic [1:0]  kind;
      logic [4:0]  rd;
      logic [3:0]  mbe;
      logic [31:0] pc;
      logic [31:0] data;
      logic [31:0] addr;
      logic [31:0] order;
`ifdef TRACE_TIMESTAMP_EN
      logic [31:0] stamp;
`endif
   } entry_t;

   entry_t        mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [31:0]   order_ctr, rep_ctr, idle_ctr;

   logic [PW-1:0] free, n_acc, n_drop;
   logic [CHANNELS-1:0] acc;
   logic [AW-1:0] slot     [CHANNELS];
   entry_t        wr_entry [CHANNELS];
   logic [31:0]   rep_next;
   logic          halt_next;
   logic          pop;
   logic [16:0]   drop_sum;
   logic [15:0]   drop_next;
   entry_t        head;

`ifdef TRACE_TIMESTAMP_EN
   logic [31:0] cycle_ctr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cycle_ctr <= '0;
      else       cycle_ctr <= cycle_ctr + 32'd1;
   end
`endif

   // NOTE: blocking assignments here are deliberate; n_acc, rep_next and halt_next are running
   // totals that each later channel must see already updated by the earlier ones.
   always_comb begin
      free      = PW'(DEPTH) - count;
      n_acc     = '0;
      n_drop    = '0;
      acc       = '0;
      rep_next  = rep_ctr;
      halt_next = halt;
      for (int i = 0; i < CHANNELS; i++) begin
         slot[i]           = wr_ptr[AW-1:0] + n_acc[AW-1:0];
         wr_entry[i]       = '0;
         wr_entry[i].kind  = commit_kind[2*i +: 2];
         wr_entry[i].rd    = commit_rd[5*i +: 5];
         wr_entry[i].mbe   = commit_mbe[4*i +: 4];
         wr_entry[i].pc    = commit_pc[32*i +: 32];
         wr_entry[i].data  = commit_data[32*i +: 32];
         wr_entry[i].addr  = commit_addr[32*i +: 32];
         wr_entry[i].order = order_ctr + 32'(n_acc);
`ifdef TRACE_TIMESTAMP_EN
         wr_entry[i].stamp = cycle_ctr;
`endif
         // Once halt is reached (earlier cycle or lower channel) every later event is ignored.
         if (commit_valid[i] && !halt_next &&
             !(kind_t'(commit_kind[2*i +: 2]) == KIND_REG && commit_rd[5*i +: 5] == 5'd0)) begin
            if (n_acc < free) begin
               acc[i] = 1'b1;
               n_acc  = n_acc + PW'(1);
            end else begin
               n_drop = n_drop + PW'(1);
            end
            if (kind_t'(commit_kind[2*i +: 2]) == KIND_BRANCH &&
                commit_addr[32*i +: 32] == commit_pc[32*i +: 32]) begin
               rep_next = rep_next + 32'd1;
               if (rep_next >= 32'(HALT_REPEAT)) halt_next = 1'b1;
            end else begin
               rep_next = '0;
            end
         end
      end
   end

   assign pop       = trace_ready && (count != '0);
   assign drop_sum  = {1'b0, drop_count} + 17'(n_drop);
   assign drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         order_ctr  <= '0;
         rep_ctr    <= '0;
         halt       <= 1'b0;
         overflow   <= 1'b0;
         drop_count <= '0;
         idle_ctr   <= '0;
         timeout    <= 1'b0;
      end else begin
         wr_ptr     <= wr_ptr + n_acc;
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         count      <= count + n_acc - PW'(pop);
         order_ctr  <= order_ctr + 32'(n_acc);
         rep_ctr    <= rep_next;
         halt       <= halt_next;
         drop_count <= drop_next;
         if (n_drop != '0) overflow <= 1'b1;
         if (|commit_valid)                              idle_ctr <= '0;
         else if (idle_ctr != 32'(TIMEOUT_CYCLES))       idle_ctr <= idle_ctr + 32'd1;
         if (idle_ctr == 32'(TIMEOUT_CYCLES)) timeout <= 1'b1;
      end
   end

   // NOTE: storage has no reset; pointers and count alone define which entries are live,
   // so a reset discards the contents without clearing the array.
   always_ff @(posedge clk) begin
      for (int i = 0; i < CHANNELS; i++) begin
         if (acc[i]) mem[slot[i]] <= wr_entry[i];
      end
   end

   assign trace_valid = (count != '0);
   assign head        = trace_valid ? mem[rd_ptr[AW-1:0]] : '0;
   assign trace_kind  = head.kind;
   assign trace_rd    = head.rd;
   assign trace_mbe   = head.mbe;
   assign trace_pc    = head.pc;
   assign trace_data  = head.data;
   assign trace_addr  = head.addr;
   assign trace_order = head.order;
`ifdef TRACE_TIMESTAMP_EN
   assign trace_time  = head.stamp;
`else
   assign trace_time  = '0;
`endif

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer (CHANNELS=2, DEPTH=4, HALT_REPEAT=2, TIMEOUT_CYCLES=10).
module tb_commit_trace_buffer;

   localparam int CH = 2;
   localparam int DP = 4;

   logic              clk;
   logic              reset;
   logic [CH-1:0]     commit_valid;
   logic [2*CH-1:0]   commit_kind;
   logic [32*CH-1:0]  commit_pc;
   logic [5*CH-1:0]   commit_rd;
   logic [32*CH-1:0]  commit_data;
   logic [32*CH-1:0]  commit_addr;
   logic [4*CH-1:0]   commit_mbe;
   logic              trace_ready;
   logic              trace_valid;
   logic [1:0]        trace_kind;
   logic [4:0]        trace_rd;
   logic [3:0]        trace_mbe;
   logic [31:0]       trace_pc, trace_data, trace_addr, trace_order, trace_time;
   logic [$clog2(DP):0] count;
   logic              overflow;
   logic [15:0]       drop_count;
   logic              halt;
   logic              timeout;

   int vectors     = 0;
   int miscompares = 0;

   commit_trace_buffer #(
      .CHANNELS(CH), .DEPTH(DP), .HALT_REPEAT(2), .TIMEOUT_CYCLES(10)
   ) dut (
      .clk(clk), .reset(reset),
      .commit_valid(commit_valid), .commit_kind(commit_kind), .commit_pc(commit_pc),
      .commit_rd(commit_rd), .commit_data(commit_data), .commit_addr(commit_addr),
      .commit_mbe(commit_mbe), .trace_ready(trace_ready),
      .trace_valid(trace_valid), .trace_kind(trace_kind), .trace_rd(trace_rd),
      .trace_mbe(trace_mbe), .trace_pc(trace_pc), .trace_data(trace_data),
      .trace_addr(trace_addr), .trace_order(trace_order), .trace_time(trace_time),
      .count(count), .overflow(overflow), .drop_count(drop_count),
      .halt(halt), .timeout(timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_time(input logic [31:0] t);
`ifdef TRACE_TIMESTAMP_EN
      return t;
`else
      return (t == 32'hFFFF_FFFF) ? 32'd0 : 32'd0;
`endif
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      commit_valid = '0;
      commit_kind  = '0;
      commit_pc    = '0;
      commit_rd    = '0;
      commit_data  = '0;
      commit_addr  = '0;
      commit_mbe   = '0;
   endtask

   task automatic drive(input int ch, input logic [1:0] kind, input logic [31:0] pc,
                        input logic [4:0] rd, input logic [31:0] data,
                        input logic [31:0] addr, input logic [3:0] mbe);
      commit_valid[ch]          = 1'b1;
      commit_kind[2*ch +: 2]    = kind;
      commit_pc[32*ch +: 32]    = pc;
      commit_rd[5*ch +: 5]      = rd;
      commit_data[32*ch +: 32]  = data;
      commit_addr[32*ch +: 32]  = addr;
      commit_mbe[4*ch +: 4]     = mbe;
   endtask

   // Asserts reset between edges, optionally checks the asynchronously cleared state, releases it.
   task automatic reset_dut(input bit do_check, input string tag);
      clear_inputs();
      trace_ready = 1'b0;
      reset = 1'b1;
      #2;
      if (do_check) begin
         check({tag, "_valid"},    32'(trace_valid), 32'd0);
         check({tag, "_count"},    32'(count),       32'd0);
         check({tag, "_overflow"}, 32'(overflow),    32'd0);
         check({tag, "_drops"},    32'(drop_count),  32'd0);
         check({tag, "_halt"},     32'(halt),        32'd0);
         check({tag, "_timeout"},  32'(timeout),     32'd0);
         check({tag, "_pc"},       trace_pc,         32'd0);
         check({tag, "_order"},    trace_order,      32'd0);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      trace_ready = 1'b0;
      clear_inputs();
      #1;
      reset_dut(1'b1, "rst");

      // Three single-channel reg commits starting in cycle 7 after reset, then drain.
      repeat (7) tick();
      drive(0, 2'd0, 32'h10, 5'd1, 32'hA1, 32'h0, 4'h0);
      tick();
      check("s1_vis_valid", 32'(trace_valid), 32'd1);
      check("s1_vis_count", 32'(count), 32'd1);
      clear_inputs();
      drive(0, 2'd0, 32'h14, 5'd2, 32'hA2, 32'h0, 4'h0);
      tick();
      clear_inputs();
      drive(0, 2'd0, 32'h18, 5'd3, 32'hA3, 32'h0, 4'h0);
      tick();
      clear_inputs();
      check("s1_count3", 32'(count), 32'd3);
      check("s1_h0_order", trace_order, 32'd0);
      check("s1_h0_rd", 32'(trace_rd), 32'd1);
      check("s1_h0_pc", trace_pc, 32'h10);
      check("s1_h0_data", trace_data, 32'hA1);
      check("s1_h0_time", trace_time, exp_time(32'd7));
      trace_ready = 1'b1;
      tick();
      check("s1_h1_order", trace_order, 32'd1);
      check("s1_h1_rd", 32'(trace_rd), 32'd2);
      check("s1_h1_time", trace_time, exp_time(32'd8));
      check("s1_count2", 32'(count), 32'd2);
      tick();
      check("s1_h2_order", trace_order, 32'd2);
      check("s1_h2_pc", trace_pc, 32'h18);
      check("s1_h2_time", trace_time, exp_time(32'd9));
      tick();
      check("s1_empty_valid", 32'(trace_valid), 32'd0);
      check("s1_empty_pc_mask", trace_pc, 32'd0);
      check("s1_empty_count", 32'(count), 32'd0);
      tick();
      check("s1_pop_empty_count", 32'(count), 32'd0);
      trace_ready = 1'b0;

      // rd = 0 filtering alongside a load on channel 1.
      reset_dut(1'b0, "");
      drive(0, 2'd0, 32'h20, 5'd0, 32'h55, 32'h0, 4'h0);
      drive(1, 2'd1, 32'h24, 5'd4, 32'hDEAD, 32'h100, 4'hF);
      tick();
      clear_inputs();
      check("s2_count", 32'(count), 32'd1);
      check("s2_kind", 32'(trace_kind), 32'd1);
      check("s2_addr", trace_addr, 32'h100);
      check("s2_mbe", 32'(trace_mbe), 32'hF);
      check("s2_order", trace_order, 32'd0);
      check("s2_drops", 32'(drop_count), 32'd0);

      // Overflow: preload 3, dual commit with a pop, then fill and drop two more.
      reset_dut(1'b0, "");
      drive(0, 2'd0, 32'h30, 5'd1, 32'h1, 32'h0, 4'h0);
      drive(1, 2'd0, 32'h34, 5'd2, 32'h2, 32'h0, 4'h0);
      tick();
      clear_inputs();
      drive(0, 2'd0, 32'h38, 5'd3, 32'h3, 32'h0, 4'h0);
      tick();
      clear_inputs();
      check("s3_pre_count", 32'(count), 32'd3);
      drive(0, 2'd0, 32'h3C, 5'd4, 32'h4, 32'h0, 4'h0);
      drive(1, 2'd0, 32'h40, 5'd5, 32'h5, 32'h0, 4'h0);
      trace_ready = 1'b1;
      tick();
      clear_inputs();
      trace_ready = 1'b0;
      check("s3_count", 32'(count), 32'd3);
      check("s3_overflow", 32'(overflow), 32'd1);
      check("s3_drops", 32'(drop_count), 32'd1);
      check("s3_head_order", trace_order, 32'd1);
      drive(0, 2'd0, 32'h44, 5'd6, 32'h6, 32'h0, 4'h0);
      tick();
      clear_inputs();
      check("s3_full_count", 32'(count), 32'd4);
      drive(0, 2'd0, 32'h48, 5'd7, 32'h7, 32'h0, 4'h0);
      drive(1, 2'd0, 32'h4C, 5'd8, 32'h8, 32'h0, 4'h0);
      tick();
      clear_inputs();
      check("s3_full_drops", 32'(drop_count), 32'd3);
      check("s3_full_count2", 32'(count), 32'd4);
      trace_ready = 1'b1;
      tick();
      trace_ready = 1'b0;
      check("s3_pop_order", trace_order, 32'd2);
      check("s3_pop_rd", 32'(trace_rd), 32'd3);

      // Asynchronous reset with a full-ish FIFO discards everything before any edge.
      reset_dut(1'b1, "midrst");

      // Halt after two consecutive self-branches; following commit is ignored.
      drive(0, 2'd3, 32'h60, 5'd0, 32'h0, 32'h60, 4'h0);
      tick();
      check("s4_halt_after1", 32'(halt), 32'd0);
      tick();
      clear_inputs();
      check("s4_halt_after2", 32'(halt), 32'd1);
      drive(0, 2'd0, 32'h64, 5'd5, 32'h9, 32'h0, 4'h0);
      tick();
      clear_inputs();
      check("s4_count", 32'(count), 32'd2);
      check("s4_head_pc", trace_pc, 32'h60);

      // A non-self branch breaks the repeat run.
      reset_dut(1'b0, "");
      drive(0, 2'd3, 32'h60, 5'd0, 32'h0, 32'h60, 4'h0);
      tick();
      clear_inputs();
      drive(0, 2'd3, 32'h60, 5'd0, 32'h0, 32'h64, 4'h0);
      tick();
      clear_inputs();
      drive(0, 2'd3, 32'h60, 5'd0, 32'h0, 32'h60, 4'h0);
      tick();
      check("s5_rep_cleared", 32'(halt), 32'd0);
      tick();
      clear_inputs();
      check("s5_halt", 32'(halt), 32'd1);

      // Halt mid-cycle: the higher channel's store is neither recorded nor dropped.
      reset_dut(1'b0, "");
      drive(0, 2'd0, 32'h70, 5'd7, 32'h7, 32'h0, 4'h0);
      tick();
      clear_inputs();
      drive(0, 2'd0, 32'h74, 5'd8, 32'h8, 32'h0, 4'h0);
      drive(1, 2'd3, 32'h80, 5'd0, 32'h0, 32'h80, 4'h0);
      tick();
      clear_inputs();
      check("s6_pre_count", 32'(count), 32'd3);
      drive(0, 2'd3, 32'h80, 5'd0, 32'h0, 32'h80, 4'h0);
      drive(1, 2'd2, 32'h84, 5'd0, 32'hBEEF, 32'h200, 4'h3);
      tick();
      clear_inputs();
      check("s6_halt", 32'(halt), 32'd1);
      check("s6_count", 32'(count), 32'd4);
      check("s6_drops", 32'(drop_count), 32'd0);
      check("s6_overflow", 32'(overflow), 32'd0);

      // Timeout after ten idle cycles; recording continues afterwards.
      reset_dut(1'b0, "");
      repeat (10) tick();
      check("s7_timeout_10", 32'(timeout), 32'd0);
      tick();
      check("s7_timeout_11", 32'(timeout), 32'd1);
      drive(0, 2'd0, 32'h90, 5'd9, 32'h99, 32'h0, 4'h0);
      tick();
      clear_inputs();
      check("s7_count", 32'(count), 32'd1);
      check("s7_rd", 32'(trace_rd), 32'd9);
      check("s7_timeout_hold", 32'(timeout), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
